// File: rtl/settings_pkg.sv
// Settings menu shared types.
// Colour constants and menu state enum.
package settings_pkg;

  localparam logic [15:0] WHITE   = 16'hFFFF;
  localparam logic [15:0] BLACK   = 16'h0000;
  localparam logic [15:0] SKYBLUE = 16'h5FFF;
  localparam logic [15:0] GREEN   = 16'h07E0;
  localparam logic [15:0] RED     = 16'hF800;

  typedef enum logic {
    BROWSE  = 1'b0,
    CONFIRM = 1'b1
  } menu_state_t;

endpackage

// File: rtl/blink_timer.sv
// Cursor blink timer.
// Toggles blink_on every BLINK_FRAMES frame ticks.
module blink_timer #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic clear,
  output logic blink_on
);

  localparam int W = $clog2(BLINK_FRAMES + 1);
  localparam logic [W-1:0] LAST = W'(BLINK_FRAMES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      blink_on <= 1'b1;
    end else if (clear) begin
      cnt      <= '0;
      blink_on <= 1'b1;
    end else if (frame_tick) begin
      if (cnt == LAST) begin
        cnt      <= '0;
        blink_on <= ~blink_on;
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/settings_menu.sv
// OLED settings menu: cursor, commit FSM
// and a single-register pixel path.
module settings_menu
  import settings_pkg::*;
#(
  parameter int N_ITEMS        = 2,
  parameter int ROW_Y0         = 35,
  parameter int ROW_H          = 9,
  parameter int BLINK_FRAMES   = 16,
  parameter int CONFIRM_FRAMES = 8,
  parameter int IDLE_FRAMES    = 600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic        text_px,
  output logic [15:0] oled_data,
  output logic [1:0]  cursor,
  output logic [1:0]  choice,
  output logic        choice_valid,
  output logic        confirm_pulse
);

  localparam logic [1:0] LAST = 2'(N_ITEMS - 1);
  localparam int IW = $clog2(IDLE_FRAMES + 1);
  localparam int CW = $clog2(CONFIRM_FRAMES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_FRAMES - 1);
  localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_FRAMES - 1);

  menu_state_t   state;
  logic          armed;
  logic [IW-1:0] idle_cnt;
  logic [CW-1:0] conf_cnt;
  logic          blink_on;
  logic          browse;
  logic          take_sel;
  logic          take_move;
  logic          accepted;
  logic          hit;
  logic [1:0]    band;
  logic          hl;
  logic [15:0]   pix_next;

  // armed masks buttons on the first edge after reset
  assign browse    = (state == BROWSE) && armed;
  assign take_sel  = browse && btn_sel;
  assign take_move = browse && !btn_sel
                   && (btn_up ^ btn_down);
  assign accepted  = take_sel | take_move;

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .clear     (accepted),
    .blink_on  (blink_on)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= BROWSE;
      armed         <= 1'b0;
      cursor        <= '0;
      choice        <= '0;
      choice_valid  <= 1'b0;
      confirm_pulse <= 1'b0;
      idle_cnt      <= '0;
      conf_cnt      <= '0;
    end else begin
      armed         <= 1'b1;
      confirm_pulse <= take_sel;
      unique case (state)
        BROWSE: begin
          if (take_sel) begin
            choice       <= cursor;
            choice_valid <= 1'b1;
            conf_cnt     <= '0;
            idle_cnt     <= '0;
            state        <= CONFIRM;
          end else if (take_move) begin
            idle_cnt <= '0;
            if (btn_up)
              cursor <= (cursor == 2'd0) ? LAST
                      : cursor - 2'd1;
            else
              cursor <= (cursor == LAST) ? 2'd0
                      : cursor + 2'd1;
          end else if (frame_tick) begin
            if (idle_cnt == IDLE_LAST) begin
              idle_cnt <= '0;
              cursor   <= choice_valid ? choice
                        : 2'd0;
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
            end
          end
        end
        CONFIRM: begin
          if (frame_tick) begin
            if (conf_cnt == CONF_LAST) begin
              conf_cnt <= '0;
              cursor   <= choice;
              state    <= BROWSE;
            end else begin
              conf_cnt <= conf_cnt + CW'(1);
            end
          end
        end
        default: state <= BROWSE;
      endcase
    end
  end

  always_comb begin
    hit  = 1'b0;
    band = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (int'(y) >= ROW_Y0 + i * ROW_H &&
          int'(y) <  ROW_Y0 + (i + 1) * ROW_H) begin
        hit  = 1'b1;
        band = 2'(i);
      end
    end
    // CONFIRM flashes on even frame counts
    hl = (state == CONFIRM) ? ~conf_cnt[0]
       : blink_on;
    pix_next = WHITE;
    if (text_px)
      pix_next = BLACK;
    else if (x < 7'd96 && hit &&
             band == cursor && hl)
      pix_next = SKYBLUE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) oled_data <= WHITE;
    else       oled_data <= pix_next;
  end

endmodule

// File: tb/tb_settings_menu.sv
// Settings menu bench: behavioural model
// checked every cycle plus literal pins.
module tb_settings_menu;

  localparam int N  = 2;
  localparam int Y0 = 35;
  localparam int RH = 9;
  localparam int BF = 3;
  localparam int CF = 8;
  localparam int IF = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        btn_up;
  logic        btn_down;
  logic        btn_sel;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        text_px;
  logic [15:0] oled_data;
  logic [1:0]  cursor;
  logic [1:0]  choice;
  logic        choice_valid;
  logic        confirm_pulse;

  settings_menu #(
    .N_ITEMS       (N),
    .ROW_Y0        (Y0),
    .ROW_H         (RH),
    .BLINK_FRAMES  (BF),
    .CONFIRM_FRAMES(CF),
    .IDLE_FRAMES   (IF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_sel      (btn_sel),
    .x            (x),
    .y            (y),
    .text_px      (text_px),
    .oled_data    (oled_data),
    .cursor       (cursor),
    .choice       (choice),
    .choice_valid (choice_valid),
    .confirm_pulse(confirm_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  int          m_cursor, m_choice;
  int          m_bticks, m_idle, m_cticks;
  bit          m_valid, m_conf, m_pulse, m_armed;
  logic [15:0] m_pix;

  function automatic bit m_hl();
    if (m_conf) return (m_cticks % 2) == 0;
    return ((m_bticks / BF) % 2) == 0;
  endfunction

  function automatic logic [15:0] m_pixel(
      int xx, int yy, bit tp);
    int b;
    if (tp) return 16'h0000;
    if (xx >= 96 || yy < Y0 || yy >= Y0 + N * RH)
      return 16'hFFFF;
    b = (yy - Y0) / RH;
    if (b == m_cursor && m_hl()) return 16'h5FFF;
    return 16'hFFFF;
  endfunction

  always @(posedge clk or posedge reset) begin
    logic [15:0] pn;
    bit as, am;
    if (reset) begin
      m_cursor = 0; m_choice = 0;
      m_bticks = 0; m_idle = 0; m_cticks = 0;
      m_valid = 0; m_conf = 0; m_pulse = 0;
      m_armed = 0; m_pix = 16'hFFFF;
    end else begin
      pn = m_pixel(int'(x), int'(y), text_px);
      as = m_armed && !m_conf && btn_sel;
      am = m_armed && !m_conf && !btn_sel
         && (btn_up != btn_down);
      m_pulse = as;
      if (m_conf) begin
        if (frame_tick) begin
          m_cticks++;
          if (m_cticks == CF) begin
            m_conf = 0;
            m_cursor = m_choice;
          end
        end
      end else if (as) begin
        m_choice = m_cursor; m_valid = 1;
        m_conf = 1; m_cticks = 0; m_idle = 0;
      end else if (am) begin
        m_cursor = btn_up ? (m_cursor + N - 1) % N
                          : (m_cursor + 1) % N;
        m_idle = 0;
      end else if (frame_tick) begin
        m_idle++;
        if (m_idle == IF) begin
          m_cursor = m_valid ? m_choice : 0;
          m_idle = 0;
        end
      end
      if (as || am) m_bticks = 0;
      else if (frame_tick) m_bticks++;
      m_pix = pn;
      m_armed = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cursor", 32'(cursor), m_cursor);
      check("choice", 32'(choice), m_choice);
      check("valid", 32'(choice_valid), 32'(m_valid));
      check("pulse", 32'(confirm_pulse), 32'(m_pulse));
      check("oled", 32'(oled_data), 32'(m_pix));
    end
  end

  task automatic step(input bit u, input bit d,
                      input bit s, input bit t,
                      input int xx, input int yy,
                      input bit tp);
    btn_up = u; btn_down = d; btn_sel = s;
    frame_tick = t;
    x = 7'(xx); y = 6'(yy); text_px = tp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_cursor", 32'(cursor), 0);
    check("rst_valid", 32'(choice_valid), 0);
    check("rst_oled", 32'(oled_data), 32'hFFFF);
    reset = 1'b0;
    chk_en = 1'b1;
    step(0, 1, 0, 0, 0, 0, 0);
    check("first_ignored", 32'(cursor), 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("down_1", 32'(cursor), 1);
    step(0, 1, 0, 0, 0, 0, 0);
    check("down_wrap", 32'(cursor), 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("up_wrap", 32'(cursor), 1);
    step(1, 1, 0, 0, 0, 0, 0);
    check("up_down", 32'(cursor), 1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 10, 36, 0);
    check("pix_sky", 32'(oled_data), 32'h5FFF);
    step(0, 0, 0, 0, 10, 36, 1);
    check("pix_text", 32'(oled_data), 32'h0000);
    step(0, 0, 0, 0, 10, 20, 0);
    check("pix_off", 32'(oled_data), 32'hFFFF);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 0, 0, 0);
    check("idle_3", 32'(cursor), 1);
    step(0, 0, 0, 1, 0, 0, 0);
    check("idle_4", 32'(cursor), 0);
    step(0, 1, 0, 0, 10, 45, 0);
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 1, 10, 45, 0);
    step(0, 1, 0, 0, 10, 45, 0);
    step(0, 1, 1, 0, 10, 45, 0);
    check("sel_choice", 32'(choice), 1);
    check("sel_pulse", 32'(confirm_pulse), 1);
    check("sel_cursor", 32'(cursor), 1);
    step(0, 0, 0, 0, 10, 45, 0);
    check("pulse_once", 32'(confirm_pulse), 0);
    for (int i = 0; i < CF; i++) begin
      step(i[0], !i[0], 1, 1, 10, 45, 0);
      check("conf_tick", 32'(cursor), 1);
      if (i < CF - 1) begin
        step(1, 0, 0, 0, 10, 45, 0);
        check("conf_hold", 32'(cursor), 1);
      end
    end
    step(1, 0, 0, 0, 10, 45, 0);
    check("conf_back", 32'(cursor), 0);
    step(0, 0, 1, 0, 10, 36, 0);
    step(0, 0, 0, 0, 10, 36, 0);
    check("conf_pix", 32'(oled_data), 32'h5FFF);
    reset = 1'b1;
    #1;
    check("arst_oled", 32'(oled_data), 32'hFFFF);
    check("arst_valid", 32'(choice_valid), 0);
    check("arst_choice", 32'(choice), 0);
    step(0, 0, 0, 0, 10, 36, 0);
    reset = 1'b0;
    step(0, 1, 0, 0, 10, 36, 0);
    check("rst_first", 32'(cursor), 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < CF; i++)
      step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("browse_up", 32'(cursor), 0);
    for (int i = 0; i < IF; i++)
      step(0, 0, 0, 1, 0, 0, 0);
    check("idle_choice", 32'(cursor), 1);
    step(0, 0, 0, 0, 100, 36, 0);
    step(0, 0, 0, 0, 100, 36, 1);
    check("x96_text", 32'(oled_data), 32'h0000);
    step(0, 1, 0, 0, 10, 43, 0);
    step(0, 0, 0, 0, 10, 43, 0);
    check("band0_top", 32'(oled_data), 32'h5FFF);
    step(0, 0, 0, 0, 10, 44, 0);
    check("band1_low", 32'(oled_data), 32'hFFFF);
    step(0, 0, 0, 0, 10, 34, 0);
    check("above_band", 32'(oled_data), 32'hFFFF);
    step(0, 0, 0, 0, 95, 35, 0);
    check("x95_band0", 32'(oled_data), 32'h5FFF);
    step(0, 0, 0, 0, 96, 35, 0);
    check("x96_white", 32'(oled_data), 32'hFFFF);
    step(0, 0, 0, 0, 10, 53, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/settings_menu.md
SETTINGS_MENU -- requirements
Module: settings_menu

Interface
REQ-001 N_ITEMS, 2, number of selectable menu rows (2..4).
REQ-002 ROW_Y0, 35, first y line of row 0.
REQ-003 ROW_H, 9, row band height in lines; ROW_Y0 + N_ITEMS*ROW_H SHALL be <= 64.
REQ-004 BLINK_FRAMES, 16, frames per cursor blink half-period (>= 1).
REQ-005 CONFIRM_FRAMES, 8, frames spent in CONFIRM.
REQ-006 IDLE_FRAMES, 600, idle frames in BROWSE before the cursor reverts to the committed choice.
REQ-007 clk  in  1  system clock.
REQ-008 reset  in  1  reset, asynchronous and active-high; one clock only.
REQ-009 frame_tick  in  1  one-cycle pulse per OLED frame.
REQ-010 btn_up, btn_down, btn_sel  in  1 each  already-debounced one-cycle pulses.
REQ-011 x  in  7  pixel column 0..95; y  in  6  pixel row 0..63.
REQ-012 text_px  in  1  glyph pixel for (x,y), supplied by the external text renderer in the same cycle.
REQ-013 oled_data  out  16  RGB565 pixel, registered.
REQ-014 cursor  out  2  row currently highlighted.
REQ-015 choice  out  2  last committed row; choice_valid  out  1  high once any commit has occurred.
REQ-016 confirm_pulse  out  1  one-cycle pulse on commit.

Function
REQ-017 FSM states BROWSE and CONFIRM; reset state BROWSE.
REQ-018 BROWSE, btn_up: cursor decrements, wrapping 0 -> N_ITEMS-1; btn_down: cursor increments, wrapping N_ITEMS-1 -> 0.
REQ-019 btn_up and btn_down in the same cycle: both ignored.
REQ-020 btn_sel has priority over btn_up/btn_down in the same cycle.
REQ-021 BROWSE, btn_sel: next cycle choice <= cursor, choice_valid <= 1, confirm_pulse = 1 for exactly one cycle, state <= CONFIRM, frame counter cleared.
REQ-022 CONFIRM: all buttons ignored; after CONFIRM_FRAMES frame_ticks return to BROWSE with cursor = choice.
REQ-023 Blink: counter of frame_ticks toggles blink_on every BLINK_FRAMES ticks; any accepted button clears the counter and sets blink_on = 1.
REQ-024 Idle: in BROWSE, IDLE_FRAMES consecutive frame_ticks with no accepted button set cursor <= choice (0 if choice_valid = 0) and restart the idle count.
REQ-025 Pixel, row band i: ROW_Y0 + i*ROW_H <= y <= ROW_Y0 + (i+1)*ROW_H - 1, for i < N_ITEMS.
REQ-026 Pixel priority: text_px = 1 -> BLACK; else band == cursor and highlight active -> SKYBLUE (5FFF); else WHITE.
REQ-027 Highlight active: in BROWSE when blink_on = 1; in CONFIRM on even frame counts (0, 2, ...), i.e. it toggles every frame.
REQ-028 x >= 96, or y outside every band, with text_px = 0 -> WHITE.
REQ-029 oled_data latency: exactly 1 clk after x, y and text_px.

Reset
REQ-030 reset asserted: state BROWSE, cursor 0, choice 0, choice_valid 0, confirm_pulse 0, oled_data WHITE (FFFF), all counters 0, blink_on 1.
REQ-031 reset mid-CONFIRM: abandon to BROWSE immediately; the committed choice is lost (choice = 0).
REQ-032 No button is acted on in the first cycle after reset deassertion.

Structure
REQ-033 Shared package settings_pkg: RGB565 colour constants (WHITE, BLACK, SKYBLUE, GREEN, RED) and the menu state enum.
REQ-034 One sub-module, blink_timer: frame_tick counter with clear input and blink_on output.
REQ-035 Cursor, choice and the FSM sit in settings_menu; the pixel path is a single register stage.

Verification
REQ-036 N_ITEMS = 2, cursor 1, btn_down -> cursor 0 (wrap); btn_up -> cursor 1.
REQ-037 btn_up and btn_down in the same cycle -> cursor unchanged; btn_sel + btn_down on cursor 1 -> choice 1, confirm_pulse one cycle, cursor 1.
REQ-038 CONFIRM_FRAMES = 8 -> 8 frame_ticks with buttons toggling: state stays CONFIRM, cursor fixed; returns to BROWSE after tick 8.
REQ-039 cursor 0, blink_on 1, x = 10, y = 36, text_px = 0 -> oled_data 5FFF one clk later; text_px = 1 -> 0000; y = 20 -> FFFF.
REQ-040 IDLE_FRAMES = 4, choice 0, cursor moved to 1 -> after 4 idle frame_ticks cursor = 0.
REQ-041 reset asserted during CONFIRM -> choice_valid 0, oled_data FFFF asynchronously, state BROWSE.
